// File: rtl/ahbl_to_apb_pkg.sv
// Shared AHB-Lite / APB definitions for the AHB-Lite to APB3 bridge.
// Holds the HTRANS and HRESP encodings and the default bus widths.
package ahbl_to_apb_pkg;

  localparam int unsigned W_HADDR_DEF = 32;
  localparam int unsigned W_PADDR_DEF = 16;
  localparam int unsigned W_DATA_DEF  = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE = 2'b00,
    HTRANS_BUSY = 2'b01,
    HTRANS_NSEQ = 2'b10,
    HTRANS_SEQ  = 2'b11
  } htrans_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  // NSEQ and SEQ request a transfer; IDLE and BUSY do not.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahbl_to_apb_if.sv
// Bundle of the AHB-Lite slave port and APB3 master port of the bridge.
// slave = the bridge's view; master = the system side (AHB master and APB peripheral).
interface ahbl_to_apb_if #(
  parameter int unsigned W_HADDR = 32,
  parameter int unsigned W_PADDR = 16,
  parameter int unsigned W_DATA  = 32
) ();

  logic               ahbls_hready;
  logic               ahbls_hready_resp;
  logic               ahbls_hresp;
  logic [W_HADDR-1:0] ahbls_haddr;
  logic               ahbls_hwrite;
  logic [1:0]         ahbls_htrans;
  logic [2:0]         ahbls_hsize;
  logic [2:0]         ahbls_hburst;
  logic [3:0]         ahbls_hprot;
  logic               ahbls_hmastlock;
  logic [W_DATA-1:0]  ahbls_hwdata;
  logic [W_DATA-1:0]  ahbls_hrdata;

  logic [W_PADDR-1:0] apbm_paddr;
  logic               apbm_psel;
  logic               apbm_penable;
  logic               apbm_pwrite;
  logic [W_DATA-1:0]  apbm_pwdata;
  logic [W_DATA-1:0]  apbm_prdata;
  logic               apbm_pready;
  logic               apbm_pslverr;

  modport slave (
    input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
           ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hwdata,
           apbm_prdata, apbm_pready, apbm_pslverr,
    output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
           apbm_paddr, apbm_psel, apbm_penable, apbm_pwrite, apbm_pwdata
  );

  modport master (
    output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
           ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hwdata,
           apbm_prdata, apbm_pready, apbm_pslverr,
    input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
           apbm_paddr, apbm_psel, apbm_penable, apbm_pwrite, apbm_pwdata
  );

endinterface

// File: rtl/ahbl_to_apb.sv
// AHB-Lite slave to APB3 master bridge: one APB transfer per AHB transfer,
// no posting or pipelining. All bus outputs except pwdata are registered.
module ahbl_to_apb
  import ahbl_to_apb_pkg::*;
#(
  parameter int unsigned W_HADDR = W_HADDR_DEF,
  parameter int unsigned W_PADDR = W_PADDR_DEF,
  parameter int unsigned W_DATA  = W_DATA_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  ahbl_to_apb_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE,
    S_ERR0,
    S_ERR1
  } state_t;

  state_t             state, state_nxt;
  logic               aphase;
  logic               capture;
  logic [W_PADDR-1:0] paddr;
  logic               psel, penable, pwrite;
  logic               hready_resp, hresp;
  logic [W_DATA-1:0]  hrdata;

  assign aphase = bus.ahbls_hready & htrans_active(bus.ahbls_htrans);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR1: begin
        if (aphase) begin
          state_nxt = S_SETUP;
          capture   = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SETUP:  state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (bus.apbm_pready) state_nxt = bus.apbm_pslverr ? S_ERR0 : S_DONE;
      end
      S_ERR0:   state_nxt = S_ERR1;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change together with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      hrdata      <= '0;
      hready_resp <= 1'b1;
      hresp       <= HRESP_OKAY;
    end else begin
      state       <= state_nxt;
      psel        <= (state_nxt == S_SETUP) || (state_nxt == S_ACCESS);
      penable     <= (state_nxt == S_ACCESS);
      hready_resp <= (state_nxt == S_IDLE) || (state_nxt == S_DONE) || (state_nxt == S_ERR1);
      hresp       <= ((state_nxt == S_ERR0) || (state_nxt == S_ERR1)) ? HRESP_ERROR : HRESP_OKAY;
      if (capture) begin
        paddr  <= bus.ahbls_haddr[W_PADDR-1:0];
        pwrite <= bus.ahbls_hwrite;
      end
      if ((state == S_ACCESS) && bus.apbm_pready && !bus.apbm_pslverr && !pwrite)
        hrdata <= bus.apbm_prdata;
    end
  end

  assign bus.apbm_paddr        = paddr;
  assign bus.apbm_psel         = psel;
  assign bus.apbm_penable      = penable;
  assign bus.apbm_pwrite       = pwrite;
  assign bus.apbm_pwdata       = bus.ahbls_hwdata;
  assign bus.ahbls_hready_resp = hready_resp;
  assign bus.ahbls_hresp       = hresp;
  assign bus.ahbls_hrdata      = hrdata;

  // Accesses are full-word and unprotected; these fields carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{bus.ahbls_haddr[W_HADDR-1:W_PADDR], bus.ahbls_hsize,
                       bus.ahbls_hburst, bus.ahbls_hprot, bus.ahbls_hmastlock};

endmodule
